output_port_arbiter: RTL

- Sits directly downstream of the output-port cluster inside a leaf interface.
- Round-robin drains the NUM_OUT_PORTS per-port packet FIFOs (first-word-fall-through: packet valid while empty=0, popped by a one-cycle rd_en_sel pulse).
- Presents one registered packet stream toward the BFT leaf link using a valid/ready handshake.
- Sustains one packet per cycle with fair port selection.

---
 rtl/output_port_arbiter_pkg.sv | 19 +
 rtl/output_port_arbiter_if.sv | 35 +++
 rtl/output_port_arbiter_rr_priority_sel.sv | 41 ++++
 rtl/output_port_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Leaf-interface package: default widths, packet type, grant-index width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package output_port_arbiter_pkg;

  localparam int PACKET_BITS_DEF   = 97;
  localparam int NUM_OUT_PORTS_DEF = 7;
  localparam int STAT_CNT_BITS_DEF = 32;

  // Grant index width; a single port still needs one bit to carry its index.
  function automatic int port_sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_SEL_BITS_DEF = port_sel_bits(NUM_OUT_PORTS_DEF);

  typedef logic [PACKET_BITS_DEF-1:0] packet_t;

endpackage

// File: rtl/output_port_arbiter_if.sv
// Bundle between the port FIFO cluster, the arbiter and the leaf link.
// Latency: n/a (wires only).
// Backpressure: dout_rdy from the link; rd_en_sel pops the FWFT FIFOs.
// Signals: internal_out/empty (FIFO heads), rd_en_sel (pop strobe),
//          dout/dout_vld/dout_rdy/dout_port (link stream), stat_pkt_cnt.
// master = arbiter side, slave = FIFO cluster + link side.
interface output_port_arbiter_if
  import output_port_arbiter_pkg::*;
#(
  parameter int PACKET_BITS   = PACKET_BITS_DEF,
  parameter int NUM_OUT_PORTS = NUM_OUT_PORTS_DEF,
  parameter int PORT_SEL_BITS = PORT_SEL_BITS_DEF,
  parameter int STAT_CNT_BITS = STAT_CNT_BITS_DEF
) ();

  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   internal_out;
  logic [NUM_OUT_PORTS-1:0]               empty;
  logic [NUM_OUT_PORTS-1:0]               rd_en_sel;
  logic [PACKET_BITS-1:0]                 dout;
  logic                                   dout_vld;
  logic                                   dout_rdy;
  logic [PORT_SEL_BITS-1:0]               dout_port;
  logic [STAT_CNT_BITS*NUM_OUT_PORTS-1:0] stat_pkt_cnt;

  modport master (
    input  internal_out, empty, dout_rdy,
    output rd_en_sel, dout, dout_vld, dout_port, stat_pkt_cnt
  );

  modport slave (
    output internal_out, empty, dout_rdy,
    input  rd_en_sel, dout, dout_vld, dout_port, stat_pkt_cnt
  );

endinterface

// File: rtl/output_port_arbiter_rr_priority_sel.sv
// Round-robin priority select: first requester after i_last_grant, wrapping at N.
// Latency: combinational.
// Backpressure: none; caller decides whether the grant is used.
// Ports: i_req (request vector), i_last_grant (previous winner),
//        o_grant (one-hot), o_grant_idx (winner index), o_any_req.
module rr_priority_sel
  import output_port_arbiter_pkg::*;
#(
  parameter int N        = NUM_OUT_PORTS_DEF,
  parameter int SEL_BITS = port_sel_bits(N)
) (
  input  logic [N-1:0]        i_req,
  input  logic [SEL_BITS-1:0] i_last_grant,
  output logic [N-1:0]        o_grant,
  output logic [SEL_BITS-1:0] o_grant_idx,
  output logic                o_any_req
);

  logic [SEL_BITS-1:0] w_cand;
  logic                w_found;

  // Scan offsets 1..N so the last winner is considered last; the modulo keeps
  // the candidate inside 0..N-1 even when N is not a power of two.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = SEL_BITS'((32'(i_last_grant) + 32'(k)) % 32'(N));
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant_idx      = w_cand;
        o_grant[w_cand]  = 1'b1;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin drain of the per-port FWFT FIFOs into one registered link stream.
// Latency: 1 cycle from empty falling to dout_vld; one packet per cycle sustained.
// Backpressure: while dout_vld & ~dout_rdy all state holds and no FIFO is popped.
// Ports: clk, reset (sync, active-high), arb_if (master modport of
//        output_port_arbiter_if). Optional macro OUTPUT_ARB_STATS_EN enables the
//        per-port accepted-packet counters; otherwise stat_pkt_cnt is tied to 0.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int PACKET_BITS   = PACKET_BITS_DEF,
  parameter int NUM_OUT_PORTS = NUM_OUT_PORTS_DEF,
  parameter int PORT_SEL_BITS = PORT_SEL_BITS_DEF,
  parameter int STAT_CNT_BITS = STAT_CNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.master arb_if
);

  localparam logic [PORT_SEL_BITS-1:0] LAST_PORT = PORT_SEL_BITS'(NUM_OUT_PORTS - 1);

  logic [PACKET_BITS-1:0]   w_port_pkt [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] w_req;
  logic [NUM_OUT_PORTS-1:0] w_grant;
  logic [PORT_SEL_BITS-1:0] w_sel_idx;
  logic                     w_any_req;
  logic                     w_load;
  logic                     w_pop;

  logic [PACKET_BITS-1:0]   r_dout;
  logic                     r_dout_vld;
  logic [PORT_SEL_BITS-1:0] r_dout_port;
  logic [PORT_SEL_BITS-1:0] r_last_grant;

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_unpack
    assign w_port_pkt[gi] = arb_if.internal_out[PACKET_BITS*gi +: PACKET_BITS];
  end

  assign w_req = ~arb_if.empty;

  rr_priority_sel #(
    .N        (NUM_OUT_PORTS),
    .SEL_BITS (PORT_SEL_BITS)
  ) u_rr_sel (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_sel_idx),
    .o_any_req    (w_any_req)
  );

  // Output register is free when empty or being drained this same cycle.
  assign w_load = ~r_dout_vld | arb_if.dout_rdy;
  // Pop is suppressed during reset so a packet is never lost to a dropped load.
  assign w_pop  = w_load & w_any_req & ~reset;

  assign arb_if.rd_en_sel = w_pop ? w_grant : '0;
  assign arb_if.dout      = r_dout;
  assign arb_if.dout_vld  = r_dout_vld;
  assign arb_if.dout_port = r_dout_port;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_dout_port  <= '0;
      r_last_grant <= LAST_PORT;
    end else if (w_pop) begin
      r_dout       <= w_port_pkt[w_sel_idx];
      r_dout_vld   <= 1'b1;
      r_dout_port  <= w_sel_idx;
      r_last_grant <= w_sel_idx;
    end else if (w_load) begin
      // Nothing to load: drop valid but keep the last packet and its port.
      r_dout_vld   <= 1'b0;
    end
  end

`ifdef OUTPUT_ARB_STATS_EN
  logic [STAT_CNT_BITS-1:0] r_stat_cnt [NUM_OUT_PORTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_stat_cnt[i] <= '0;
      end
    end else if (r_dout_vld && arb_if.dout_rdy) begin
      r_stat_cnt[r_dout_port] <= r_stat_cnt[r_dout_port] + STAT_CNT_BITS'(1);
    end
  end

  for (genvar gs = 0; gs < NUM_OUT_PORTS; gs++) begin : g_stat
    assign arb_if.stat_pkt_cnt[STAT_CNT_BITS*gs +: STAT_CNT_BITS] = r_stat_cnt[gs];
  end
`else
  assign arb_if.stat_pkt_cnt = '0;
`endif

endmodule
